// File: rtl/dht11_responder.sv
// -----------------------------------------------------------------------------
// dht11_responder
// Emulates the device side of a DHT11 single-wire sensor. Waits for a host start
// pulse, then answers with the response preamble, 40 data bits (4 payload bytes
// followed by their 8-bit checksum, MSB first) and the end pulse. The bus is
// driven open-drain: the block either pulls it low or releases it.
//
// Ports
//   i_Clock          system clock
//   i_Reset          asynchronous, active-high reset
//   i_Enable         allows start detection (only looked at in IDLE)
//   i_Data[31:0]     payload {hum_int, hum_dec, temp_int, temp_dec}
//   i_Dht_Line       raw bus level from the pad
//   o_Dht_Drive_Low  1 = pull bus low, 0 = release
//   o_Busy           high from start acceptance until the end pulse is released
//   o_Done           one-cycle pulse when a frame completes
//   o_Start_Err      one-cycle pulse when a host low was too short
//   debug_state      current FSM state encoding
//
// state       | meaning
// ------------+---------------------------------------------------------------
// IDLE        | released, waiting for a falling edge with i_Enable high
// HOST_LOW    | timing the host start low (saturating at START_MIN_US)
// RESP_WAIT   | released for RESP_DELAY_US after the host lets go
// RESP_LOW    | response low phase
// RESP_HIGH   | response released phase
// BIT_LOW     | low preamble of a data bit
// BIT_HIGH    | released for a '0' or '1' duration, then shift
// END_LOW     | final low pulse, then release and report done
// -----------------------------------------------------------------------------
module dht11_responder #(
    parameter int CLK_MHZ       = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int RESP_LOW_US   = 80,
    parameter int RESP_HIGH_US  = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 27,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic [31:0] i_Data,
    input  logic        i_Dht_Line,
    output logic        o_Dht_Drive_Low,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Start_Err,
    output logic [3:0]  debug_state
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOST_LOW  = 4'd1,
        ST_RESP_WAIT = 4'd2,
        ST_RESP_LOW  = 4'd3,
        ST_RESP_HIGH = 4'd4,
        ST_BIT_LOW   = 4'd5,
        ST_BIT_HIGH  = 4'd6,
        ST_END_LOW   = 4'd7
    } state_t;

    localparam int PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int US_W  = 16;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_MHZ - 1);
    localparam logic [US_W-1:0]  START_MIN = US_W'(START_MIN_US);

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [39:0]       shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              armed_q, armed_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              line_s;
    logic              us_tick;
    logic [US_W-1:0]   phase_us;
    logic              phase_done;
    logic [7:0]        csum;

    assign line_s  = sync2_q;
    assign us_tick = (pre_q == PRE_LAST);
    assign csum    = i_Data[31:24] + i_Data[23:16] + i_Data[15:8] + i_Data[7:0];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        armed_d    = armed_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        phase_us   = '0;
        phase_done = 1'b0;

        case (state_q)
            ST_RESP_WAIT: phase_us = US_W'(RESP_DELAY_US);
            ST_RESP_LOW:  phase_us = US_W'(RESP_LOW_US);
            ST_RESP_HIGH: phase_us = US_W'(RESP_HIGH_US);
            ST_BIT_LOW:   phase_us = US_W'(BIT_LOW_US);
            ST_BIT_HIGH:  phase_us = shift_q[39] ? US_W'(BIT1_HIGH_US) : US_W'(BIT0_HIGH_US);
            ST_END_LOW:   phase_us = US_W'(BIT_LOW_US);
            default:      phase_us = '0;
        endcase

        // Last cycle of an N-us phase: the next edge enters the next state.
        phase_done = us_tick && (us_q == phase_us - US_W'(1));

        case (state_q)
            ST_IDLE: begin
                // Only a high seen in IDLE arms detection, so a bus still low
                // after a frame (or after reset) is never taken as a start.
                if (line_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && i_Enable && !line_s) begin
                    state_d = ST_HOST_LOW;
                end
            end
            ST_HOST_LOW: begin
                if (line_s) begin
                    if (us_q >= START_MIN) begin
                        shift_d   = {i_Data, csum};
                        bit_cnt_d = '0;
                        state_d   = ST_RESP_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP_WAIT: if (phase_done) state_d = ST_RESP_LOW;
            ST_RESP_LOW:  if (phase_done) state_d = ST_RESP_HIGH;
            ST_RESP_HIGH: if (phase_done) state_d = ST_BIT_LOW;
            ST_BIT_LOW:   if (phase_done) state_d = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
                if (phase_done) begin
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd39) ? ST_END_LOW : ST_BIT_LOW;
                end
            end
            ST_END_LOW: begin
                if (phase_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_IDLE) begin
            armed_d = 1'b0;
        end
    end

    // Microsecond prescaler and phase counter restart on every state entry.
    always_comb begin
        pre_d = '0;
        us_d  = '0;
        if (state_d == state_q && state_q != ST_IDLE) begin
            pre_d = us_tick ? '0 : pre_q + PRE_W'(1);
            us_d  = us_q;
            if (us_tick && !(state_q == ST_HOST_LOW && us_q >= START_MIN)) begin
                us_d = us_q + US_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pre_q     <= '0;
            us_q      <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= i_Dht_Line;
            sync2_q   <= sync1_q;
            pre_q     <= pre_d;
            us_q      <= us_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            armed_q   <= armed_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Decoded straight from the state so reset releases the bus without a clock.
    assign o_Dht_Drive_Low = (state_q == ST_RESP_LOW) || (state_q == ST_BIT_LOW) ||
                             (state_q == ST_END_LOW);
    assign o_Busy          = (state_q != ST_IDLE) && (state_q != ST_HOST_LOW);
    assign o_Done          = done_q;
    assign o_Start_Err     = err_q;
    assign debug_state     = state_q;

endmodule

// File: tb/tb_dht11_responder.sv
module tb_dht11_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] data_in = '0;
    logic        host_low = 1'b0;
    logic        line;
    logic        drive_low, busy, done, start_err;
    logic [3:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    int done_cnt = 0;
    int err_cnt = 0;
    int busy_seen = 0;
    int drive_seen = 0;

    // Wired-AND bus: host and responder both pull low, pull-up otherwise.
    assign line = host_low ? 1'b0 : (drive_low ? 1'b0 : 1'b1);

    always #5 clk = ~clk;

    dht11_responder #(
        .CLK_MHZ(1),
        .START_MIN_US(100)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Enable(enable),
        .i_Data(data_in),
        .i_Dht_Line(line),
        .o_Dht_Drive_Low(drive_low),
        .o_Busy(busy),
        .o_Done(done),
        .o_Start_Err(start_err),
        .debug_state(dbg_state)
    );

    always @(negedge clk) begin
        if (done)      done_cnt++;
        if (start_err) err_cnt++;
        if (busy)      busy_seen++;
        if (drive_low) drive_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        #1;
        done_cnt = 0;
        err_cnt = 0;
        busy_seen = 0;
        drive_seen = 0;
    endtask

    task automatic host_start(input int low_cycles);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_cycles) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Counts negedge samples for which drive_low stays at lvl, starting with the
    // current sample; returns on the first sample of the other level.
    task automatic count_level(input logic lvl, output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (drive_low !== lvl || n >= 20000) break;
            n++;
        end
    endtask

    // mode 0: plain, 1: i_Data cleared during bit 5, 2: i_Enable dropped during bit 5
    task automatic run_frame(input string tag, input logic [31:0] data,
                             input int low_cycles, input int mode);
        logic [39:0] exp_bits;
        logic [39:0] rx;
        int          sum;
        int          n;
        int          wait_n;
        int          exp_hi;

        sum = 0;
        for (int b = 0; b < 4; b++) sum += int'((data >> (8 * b)) & 32'hFF);
        exp_bits = {data, 8'(sum % 256)};
        rx = '0;

        data_in = data;
        clear_mon();
        host_start(low_cycles);

        wait_n = 0;
        forever begin
            @(negedge clk);
            if (drive_low === 1'b1 || wait_n >= 1000) break;
            wait_n++;
        end
        if (drive_low !== 1'b1) begin
            chk({tag, "_no_response"}, 64'(drive_low), 64'd1);
            return;
        end
        chk({tag, "_resp_delay_ok"}, 64'(wait_n >= 30 && wait_n <= 34), 64'd1);
        chk({tag, "_busy_in_frame"}, 64'(busy), 64'd1);

        count_level(1'b1, n);
        chk({tag, "_resp_low"}, 64'(n), 64'd80);
        count_level(1'b0, n);
        chk({tag, "_resp_high"}, 64'(n), 64'd80);

        for (int i = 0; i < 40; i++) begin
            if (i == 5 && mode == 1) data_in = 32'h0;
            if (i == 5 && mode == 2) enable = 1'b0;
            count_level(1'b1, n);
            chk($sformatf("%s_bit%0d_low", tag, i), 64'(n), 64'd50);
            count_level(1'b0, n);
            exp_hi = exp_bits[39 - i] ? 70 : 27;
            chk($sformatf("%s_bit%0d_high", tag, i), 64'(n), 64'(exp_hi));
            rx = {rx[38:0], (n > 48)};
        end

        count_level(1'b1, n);
        chk({tag, "_end_low"}, 64'(n), 64'd50);
        repeat (5) @(negedge clk);
        chk({tag, "_bits"}, 64'(rx), 64'(exp_bits));
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_idle_after"}, 64'(dbg_state), 64'd0);
        chk({tag, "_released_after"}, 64'(drive_low), 64'd0);
        enable = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_drive", 64'(drive_low), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(start_err), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_frame("nominal", 32'h3700_1A00, 150, 0);
        run_frame("wrap", 32'hFFFF_0102, 130, 0);

        // Short start request
        clear_mon();
        host_start(60);
        repeat (60) @(negedge clk);
        chk("short_err_pulse", 64'(err_cnt), 64'd1);
        chk("short_no_drive", 64'(drive_seen), 64'd0);
        chk("short_no_busy", 64'(busy_seen), 64'd0);
        chk("short_idle", 64'(dbg_state), 64'd0);

        run_frame("datachg", 32'hA5C3_5A3C, 140, 1);
        run_frame("endrop", 32'h1234_5678, 120, 2);

        // Async reset during the response low phase
        data_in = 32'h4242_1111;
        clear_mon();
        host_start(150);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (drive_low === 1'b1) break;
        end
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_release", 64'(drive_low), 64'd0);
        chk("areset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("areset_no_done", 64'(done_cnt), 64'd0);
        run_frame("after_reset", 32'h4242_1111, 150, 0);

        // Enable gating
        enable = 1'b0;
        clear_mon();
        host_start(200);
        repeat (150) @(negedge clk);
        chk("gated_no_drive", 64'(drive_seen), 64'd0);
        chk("gated_no_busy", 64'(busy_seen), 64'd0);
        chk("gated_no_err", 64'(err_cnt), 64'd0);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        run_frame("enabled", 32'h0F0F_F0F0, 150, 0);

        // Random payloads and start lengths
        for (int r = 0; r < 4; r++) begin
            run_frame($sformatf("rand%0d", r), $urandom, int'($urandom_range(110, 200)), 0);
            clear_mon();
            host_start(int'($urandom_range(20, 90)));
            repeat (40) @(negedge clk);
            chk($sformatf("rand%0d_short_err", r), 64'(err_cnt), 64'd1);
            chk($sformatf("rand%0d_short_busy", r), 64'(busy_seen), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
